frame_gen: RTL and testbench

- Synthesizable traffic generator that emits typed frames into the TX write FIFO on the write_clk (400 MHz) domain.
- Each frame is a header word (type 01), N payload words (type 00) and a trailer word (type 10). This replaces hand-sequenced we/din/dtin stimulus.
- Parametrised in word width, payload length, sequence width and payload mode (incrementing or PRBS).
- Honours FIFO backpressure and link_ready; sits between a control register block and the TX FIFO write port.

---
 rtl/frame_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_frame_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_gen.sv
`default_nettype none
// ============================================================================
// Module  : frame_gen
// Brief   : Typed frame traffic generator (header / payload / trailer words)
//           driving the TX write FIFO on the write_clk domain.
// Revision: 1.0 - initial release
// ============================================================================
module frame_gen #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 16,
  parameter int SEQ_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              write_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              link_ready,
  input  logic              fifo_full,
  input  logic              mode,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic [GAP_W-1:0]  gap_len,
  input  logic [CNT_W-1:0]  frame_count,
  input  logic [DATA_W-1:0] seed,
  output logic              we,
  output logic [DATA_W-1:0] din,
  output logic [1:0]        dtin,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  frames_sent
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_HEAD = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_TAIL = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam logic [1:0] T_DATA = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  logic [2:0]        state_q,   state_d;
  logic [DATA_W-1:0] din_q,     din_d;
  logic [1:0]        dtin_q,    dtin_d;
  logic [CNT_W-1:0]  frames_q,  frames_d;
  logic [SEQ_W-1:0]  seq_q,     seq_d;
  logic [31:0]       gen_q,     gen_d;
  logic [DATA_W-1:0] csum_q,    csum_d;
  logic [LEN_W-1:0]  wcnt_q,    wcnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [LEN_W-1:0]  len_q,     len_d;
  logic [GAP_W-1:0]  gap_q,     gap_d;
  logic [CNT_W-1:0]  fcnt_q,    fcnt_d;
  logic              mode_q,    mode_d;
  logic              done_q,    done_d;

  function automatic logic [DATA_W-1:0] hdr_word(input logic [LEN_W-1:0] len,
                                                 input logic [SEQ_W-1:0] seq);
    logic [DATA_W-1:0] w;
    w = '0;
    w[DATA_W-1 -: LEN_W] = len;
    w[SEQ_W-1:0]         = seq;
    return w;
  endfunction

  // Left-shifting LFSR, feedback into bit 0; from state 1 it walks 1, 3, 7, ...
  function automatic logic [31:0] gen_step(input logic m, input logic [31:0] g);
    if (m) return {g[30:0], g[31] ^ g[21] ^ g[0]};
    return g + 32'd1;
  endfunction

  assign we = ((state_q == S_HEAD) || (state_q == S_DATA) || (state_q == S_TAIL)) && !fifo_full;
  assign din         = din_q;
  assign dtin        = dtin_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign frames_sent = frames_q;

  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    dtin_d    = dtin_q;
    frames_d  = frames_q;
    seq_d     = seq_q;
    gen_d     = gen_q;
    csum_d    = csum_q;
    wcnt_d    = wcnt_q;
    gap_cnt_d = gap_cnt_q;
    len_d     = len_q;
    gap_d     = gap_q;
    fcnt_d    = fcnt_q;
    mode_d    = mode_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = payload_len;
          gap_d    = gap_len;
          fcnt_d   = frame_count;
          mode_d   = mode;
          frames_d = '0;
          seq_d    = '0;
          csum_d   = '0;
          wcnt_d   = '0;
          gen_d    = (mode && (seed == '0)) ? 32'd1 : 32'(seed);
          din_d    = hdr_word(payload_len, '0);
          dtin_d   = T_HEAD;
          state_d  = link_ready ? S_HEAD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (link_ready) begin
          din_d   = hdr_word(len_q, seq_q);
          dtin_d  = T_HEAD;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        if (we) begin
          wcnt_d = '0;
          if (len_q == '0) begin
            din_d   = csum_q;
            dtin_d  = T_TAIL;
            state_d = S_TAIL;
          end else begin
            din_d   = gen_q[DATA_W-1:0];
            dtin_d  = T_DATA;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (we) begin
          csum_d = csum_q ^ din_q;
          gen_d  = gen_step(mode_q, gen_q);
          wcnt_d = wcnt_q + LEN_W'(1);
          if (wcnt_d == len_q) begin
            din_d   = csum_d;
            dtin_d  = T_TAIL;
            state_d = S_TAIL;
          end else begin
            din_d = gen_d[DATA_W-1:0];
          end
        end
      end
      S_TAIL: begin
        if (we) begin
          frames_d = frames_q + CNT_W'(1);
          seq_d    = seq_q + SEQ_W'(1);
          csum_d   = '0;
          if (abort || ((fcnt_q != '0) && (frames_d == fcnt_q))) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (gap_q == '0) begin
            din_d   = hdr_word(len_q, seq_d);
            dtin_d  = T_HEAD;
            state_d = link_ready ? S_HEAD : S_WAIT;
          end else begin
            gap_cnt_d = gap_q;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          din_d   = hdr_word(len_q, seq_q);
          dtin_d  = T_HEAD;
          state_d = link_ready ? S_HEAD : S_WAIT;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      din_q     <= '0;
      dtin_q    <= T_DATA;
      frames_q  <= '0;
      seq_q     <= '0;
      gen_q     <= 32'd1;
      csum_q    <= '0;
      wcnt_q    <= '0;
      gap_cnt_q <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      fcnt_q    <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      dtin_q    <= dtin_d;
      frames_q  <= frames_d;
      seq_q     <= seq_d;
      gen_q     <= gen_d;
      csum_q    <= csum_d;
      wcnt_q    <= wcnt_d;
      gap_cnt_q <= gap_cnt_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      fcnt_q    <= fcnt_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_frame_gen
// Brief   : Scoreboard bench for frame_gen: expected words are queued with
//           their cycle offset from start and popped by a write monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_frame_gen;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int GAP_W  = 16;
  localparam int SEQ_W  = 8;
  localparam int CNT_W  = 16;

  logic              write_clk   = 1'b0;
  logic              rst_n       = 1'b0;
  logic              start       = 1'b0;
  logic              abort       = 1'b0;
  logic              link_ready  = 1'b1;
  logic              fifo_full   = 1'b0;
  logic              mode        = 1'b0;
  logic [LEN_W-1:0]  payload_len = '0;
  logic [GAP_W-1:0]  gap_len     = '0;
  logic [CNT_W-1:0]  frame_count = '0;
  logic [DATA_W-1:0] seed        = '0;
  logic              we;
  logic [DATA_W-1:0] din;
  logic [1:0]        dtin;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  frames_sent;

  frame_gen #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W), .SEQ_W(SEQ_W), .CNT_W(CNT_W)
  ) dut (
    .write_clk  (write_clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .link_ready (link_ready),
    .fifo_full  (fifo_full),
    .mode       (mode),
    .payload_len(payload_len),
    .gap_len    (gap_len),
    .frame_count(frame_count),
    .seed       (seed),
    .we         (we),
    .din        (din),
    .dtin       (dtin),
    .busy       (busy),
    .done       (done),
    .frames_sent(frames_sent)
  );

  always #5 write_clk = ~write_clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  t;
    int          c;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   t0       = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b1;

  always @(posedge write_clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Write monitor: every accepted word must match the head of the scoreboard,
  // including the cycle (relative to start) on which it appears.
  always @(negedge write_clk) begin : mon
    exp_t e;
    if (mon_en && rst_n && we) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 1'b0, {30'b0, dtin, din}, 64'h0);
      end else begin
        e = sb.pop_front();
        check("word", (din === e.d) && (dtin === e.t) && ((cyc - t0) == e.c),
              {16'(cyc - t0), 14'b0, dtin, din}, {16'(e.c), 14'b0, e.t, e.d});
      end
    end
  end

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] t, input int c);
    exp_t e;
    e.d = d;
    e.t = t;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic launch(input logic m, input logic [LEN_W-1:0] len,
                        input logic [GAP_W-1:0] gap, input logic [CNT_W-1:0] cnt,
                        input logic [DATA_W-1:0] sd);
    mode        = m;
    payload_len = len;
    gap_len     = gap;
    frame_count = cnt;
    seed        = sd;
    start       = 1'b1;
    t0          = cyc;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int exp_c, input int exp_frames, input string name);
    bit seen;
    int dc;
    seen = 1'b0;
    dc   = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge write_clk);
      if (done) begin
        seen = 1'b1;
        dc   = cyc - t0;
      end
    end
    check({name, "_done_cycle"}, seen && (dc == exp_c), 64'(dc), 64'(exp_c));
    check({name, "_frames_sent"}, frames_sent == CNT_W'(exp_frames),
          64'(frames_sent), 64'(exp_frames));
    check({name, "_drained"}, sb.size() == 0, 64'(sb.size()), 64'h0);
    @(negedge write_clk);
    check({name, "_done_pulse_idle"}, !done && !busy, {62'b0, done, busy}, 64'h0);
    repeat (3) tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "simulation did not complete");
  end

  logic [31:0] tr3 [3];

  initial begin : drive
    rst_n = 1'b0;
    repeat (3) @(posedge write_clk);
    #1;
    check("reset_state",
          !we && (din == '0) && (dtin == 2'b00) && !busy && !done && (frames_sent == '0),
          {13'b0, we, busy, done, dtin, frames_sent, din}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Incrementing frame, 6 payload words
    push(32'h0600_0000, 2'b01, 1);
    for (int i = 0; i < 6; i++) push(32'hA1A2_A3A4 + 32'(i), 2'b00, 2 + i);
    push(32'h0000_0001, 2'b10, 8);
    launch(1'b0, 8'd6, 16'd0, 16'd1, 32'hA1A2_A3A4);
    wait_done(9, 1, "incr");

    // Same frame with 5 cycles of backpressure on the 3rd data word
    push(32'h0600_0000, 2'b01, 1);
    for (int i = 0; i < 6; i++) push(32'hA1A2_A3A4 + 32'(i), 2'b00, (i < 2) ? 2 + i : 7 + i);
    push(32'h0000_0001, 2'b10, 13);
    launch(1'b0, 8'd6, 16'd0, 16'd1, 32'hA1A2_A3A4);
    repeat (3) tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge write_clk);
      check("bp_hold", !we && (din == 32'hA1A2_A3A6) && (dtin == 2'b00),
            {29'b0, we, dtin, din}, {32'b0, 32'hA1A2_A3A6});
      tick();
    end
    fifo_full = 1'b0;
    wait_done(14, 1, "bp");

    // Three frames, gap of 4, payload continues across frames
    tr3[0] = 32'h03;
    tr3[1] = 32'h07;
    tr3[2] = 32'h03;
    for (int f = 0; f < 3; f++) begin
      push(32'h0200_0000 | 32'(f), 2'b01, 1 + 8 * f);
      push(32'h11 + 32'(2 * f), 2'b00, 2 + 8 * f);
      push(32'h12 + 32'(2 * f), 2'b00, 3 + 8 * f);
      push(tr3[f], 2'b10, 4 + 8 * f);
    end
    launch(1'b0, 8'd2, 16'd4, 16'd3, 32'h11);
    wait_done(21, 3, "multi");

    // PRBS from a zero seed
    push(32'h0300_0000, 2'b01, 1);
    push(32'h1, 2'b00, 2);
    push(32'h3, 2'b00, 3);
    push(32'h7, 2'b00, 4);
    push(32'h5, 2'b10, 5);
    launch(1'b1, 8'd3, 16'd0, 16'd1, 32'h0);
    wait_done(6, 1, "prbs");

    // Empty payload
    push(32'h0, 2'b01, 1);
    push(32'h0, 2'b10, 2);
    launch(1'b0, 8'd0, 16'd0, 16'd1, 32'h1234);
    wait_done(3, 1, "len0");

    // Link down at start
    link_ready = 1'b0;
    push(32'h0100_0000, 2'b01, 5);
    push(32'h55, 2'b00, 6);
    push(32'h55, 2'b10, 7);
    launch(1'b0, 8'd1, 16'd0, 16'd1, 32'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge write_clk);
      check("link_wait", busy && !we, {62'b0, busy, we}, 64'h2);
      tick();
    end
    link_ready = 1'b1;
    wait_done(8, 1, "link");

    // Continuous run, abort raised mid-DATA of frame 2
    push(32'h0400_0000, 2'b01, 1);
    for (int i = 0; i < 4; i++) push(32'h101 + 32'(i), 2'b00, 2 + i);
    push(32'h4, 2'b10, 6);
    push(32'h0400_0001, 2'b01, 9);
    for (int i = 0; i < 4; i++) push(32'h105 + 32'(i), 2'b00, 10 + i);
    push(32'hC, 2'b10, 14);
    launch(1'b0, 8'd4, 16'd2, 16'd0, 32'h101);
    repeat (10) tick();
    abort = 1'b1;
    wait_done(15, 2, "abort");
    abort = 1'b0;

    // Asynchronous reset in the middle of frame 2
    mon_en = 1'b0;
    launch(1'b0, 8'd1, 16'd0, 16'd0, 32'h7);
    repeat (4) tick();
    @(negedge write_clk);
    check("pre_reset", busy && (frames_sent == 16'd1), {47'b0, busy, frames_sent}, 64'h1_0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", !we && !busy && (frames_sent == '0) && (din == '0),
          {14'b0, we, busy, frames_sent, din}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
